// File: rtl/fft_read_ram.sv
// Readback stage for the FFT result buffer: reads a 2^AWIDTH-entry RAM once per
// frame (linear or bit-reversed) and streams {im, re} samples on valid/ready.
module fft_read_ram #(
    parameter int AWIDTH = 7,
    parameter int DWIDTH = 32,
    parameter int BITREV = 1
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                en_in,
    output logic                ready_out,
    output logic                done,
    output logic                rd_en,
    output logic [AWIDTH-1:0]   rd_addr,
    input  logic [DWIDTH-1:0]   rd_q,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic [DWIDTH/2-1:0] out_im,
    output logic [DWIDTH/2-1:0] out_re,
    output logic                out_last
);

    localparam int HW = DWIDTH / 2;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    typedef struct packed {
        logic          last;
        logic [HW-1:0] im;
        logic [HW-1:0] re;
    } entry_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;
    logic              inflight_q;
    logic              inflight_last_q;
    entry_t            buf_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q, count_d;
    logic              done_q, done_d;

    logic              push;
    logic              pop;
    logic              issue;
    logic [1:0]        occ;
    logic              is_final_idx;
    entry_t            head;

    function automatic logic [AWIDTH-1:0] bit_reverse(input logic [AWIDTH-1:0] a);
        logic [AWIDTH-1:0] r;
        for (int i = 0; i < AWIDTH; i++) begin
            r[i] = a[AWIDTH-1-i];
        end
        return r;
    endfunction

    assign head         = buf_q[rd_ptr_q];
    assign out_vld      = (count_q != 2'd0);
    assign pop          = out_vld && out_rdy;
    assign push         = inflight_q;
    // Credit: buffered + in-flight samples, the read latency is hidden by keeping this <= 2.
    assign occ          = count_q + {1'b0, inflight_q};
    assign is_final_idx = (cnt_q == {AWIDTH{1'b1}});

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_in) begin
                    state_d = READ;
                    cnt_d   = '0;
                end
            end
            READ: begin
                issue = (occ < 2'd2) || ((occ == 2'd2) && pop);
                if (issue) begin
                    cnt_d = cnt_q + 1'b1;
                    if (is_final_idx) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last-tagged entry is the final sample; popping it empties the pipeline.
                if (pop && head.last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    assign rd_en     = issue;
    assign rd_addr   = (BITREV != 0) ? bit_reverse(cnt_q) : cnt_q;
    assign ready_out = (state_q == IDLE);
    assign done      = done_q;
    assign out_im    = head.im;
    assign out_re    = head.re;
    assign out_last  = head.last;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            done_q          <= 1'b0;
            // NOTE: the 2-entry buffer is reset because out_* expose the head entry directly.
            buf_q[0]        <= '0;
            buf_q[1]        <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && is_final_idx;
            count_q         <= count_d;
            done_q          <= done_d;
            if (push) begin
                buf_q[wr_ptr_q] <= '{last: inflight_last_q,
                                     im:   rd_q[DWIDTH-1:HW],
                                     re:   rd_q[HW-1:0]};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_fft_read_ram.sv
// Directed bench for fft_read_ram: linear and bit-reversed instances (AWIDTH=3)
// share clock, reset, en_in and out_rdy; each has its own RAM model.
module tb_fft_read_ram;

    localparam int AW = 3;
    localparam int DW = 32;
    localparam int N  = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic out_rdy = 1'b1;

    logic          ready_l, done_l, rd_en_l, out_vld_l, out_last_l;
    logic [AW-1:0] rd_addr_l;
    logic [DW-1:0] rd_q_l = '0;
    logic [15:0]   out_im_l, out_re_l;

    logic          ready_r, done_r, rd_en_r, out_vld_r, out_last_r;
    logic [AW-1:0] rd_addr_r;
    logic [DW-1:0] rd_q_r = '0;
    logic [15:0]   out_im_r, out_re_r;

    int n_checks = 0;
    int n_err    = 0;

    logic [AW-1:0] rev_tab [N] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    typedef struct {
        logic [15:0] im_l, re_l, im_r, re_r;
        logic        last_l, last_r;
    } sample_t;
    sample_t sb[$];

    typedef struct {
        bit          en;
        bit          rd_en;
        logic [AW-1:0] addr_l, addr_r;
        bit          vld;
        logic [15:0] im_l, re_l, im_r;
        bit          last;
        bit          done;
        bit          ready;
    } vec_t;
    vec_t tab [12];

    always #5 clk = ~clk;

    fft_read_ram #(.AWIDTH(AW), .DWIDTH(DW), .BITREV(0)) dut_lin (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .ready_out(ready_l), .done(done_l),
        .rd_en(rd_en_l), .rd_addr(rd_addr_l), .rd_q(rd_q_l), .out_vld(out_vld_l),
        .out_rdy(out_rdy), .out_im(out_im_l), .out_re(out_re_l), .out_last(out_last_l)
    );

    fft_read_ram #(.AWIDTH(AW), .DWIDTH(DW), .BITREV(1)) dut_rev (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .ready_out(ready_r), .done(done_r),
        .rd_en(rd_en_r), .rd_addr(rd_addr_r), .rd_q(rd_q_r), .out_vld(out_vld_r),
        .out_rdy(out_rdy), .out_im(out_im_r), .out_re(out_re_r), .out_last(out_last_r)
    );

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        return {16'(a), 16'(a) + 16'd100};
    endfunction

    always @(posedge clk) begin
        if (rd_en_l) rd_q_l <= ram_word(rd_addr_l);
        if (rd_en_r) rd_q_r <= ram_word(rd_addr_r);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        tick();
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ready_l"}, 32'(ready_l), 32'd1);
        check({tag, " ready_r"}, 32'(ready_r), 32'd1);
        check({tag, " done"}, 32'(done_l | done_r), 32'd0);
        check({tag, " rd_en"}, 32'(rd_en_l | rd_en_r), 32'd0);
        check({tag, " rd_addr"}, 32'({rd_addr_l, rd_addr_r}), 32'd0);
        check({tag, " out_vld"}, 32'(out_vld_l | out_vld_r), 32'd0);
        check({tag, " out_last"}, 32'(out_last_l | out_last_r), 32'd0);
        check({tag, " out_im_re"}, {out_im_l, out_re_l} | {out_im_r, out_re_r}, 32'd0);
    endtask

    // Compare the collected samples against the expected frame: index order, rev order, last on N-1.
    task automatic check_frame(input string tag);
        check({tag, " n_samples"}, 32'(sb.size()), 32'(N));
        for (int i = 0; i < sb.size() && i < N; i++) begin
            check($sformatf("%s lin im[%0d]", tag, i), 32'(sb[i].im_l), 32'(i));
            check($sformatf("%s lin re[%0d]", tag, i), 32'(sb[i].re_l), 32'(i + 100));
            check($sformatf("%s rev im[%0d]", tag, i), 32'(sb[i].im_r), 32'(rev_tab[i]));
            check($sformatf("%s rev re[%0d]", tag, i), 32'(sb[i].re_r), 32'(rev_tab[i]) + 32'd100);
            check($sformatf("%s last[%0d]", tag, i), 32'({sb[i].last_l, sb[i].last_r}),
                  (i == N - 1) ? 32'd3 : 32'd0);
        end
    endtask

    // mode 0: out_rdy=1; 1: 5-cycle stall from first out_vld; 2: random out_rdy.
    task automatic run_rest(input int mode, input string tag);
        bit stall_started = 1'b0;
        int stall_left = 0;
        bit done_seen = 1'b0;
        sb.delete();
        for (int c = 0; c < 200 && !done_seen; c++) begin
            tick();
            case (mode)
                1: begin
                    if (!stall_started && out_vld_l) begin
                        stall_started = 1'b1;
                        stall_left    = 5;
                    end
                    out_rdy = (stall_left == 0);
                end
                2:       out_rdy = 1'($urandom_range(0, 1));
                default: out_rdy = 1'b1;
            endcase
            @(negedge clk);
            if (stall_left > 0) begin
                check($sformatf("%s stall rd_en c=%0d", tag, c), 32'(rd_en_l | rd_en_r), 32'd0);
                check($sformatf("%s stall vld c=%0d", tag, c), 32'(out_vld_l & out_vld_r), 32'd1);
                check($sformatf("%s stall data c=%0d", tag, c), {out_im_l, out_re_l}, {16'd0, 16'd100});
                stall_left--;
            end
            if (done_l) begin
                done_seen = 1'b1;
                check({tag, " done_rev"}, 32'(done_r), 32'd1);
            end
            if (out_vld_l && out_rdy) begin
                sb.push_back('{im_l: out_im_l, re_l: out_re_l, im_r: out_im_r, re_r: out_re_r,
                               last_l: out_last_l, last_r: out_last_r});
            end
        end
        check({tag, " done_seen"}, 32'(done_seen), 32'd1);
        if (mode == 1) check({tag, " stall_seen"}, 32'(stall_started), 32'd1);
        out_rdy = 1'b1;
        check_frame(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;

        // Expected cycle-by-cycle behaviour after en_in in cycle T, out_rdy=1; en pulses at
        // T+4 (READ) and T+10 (DRAIN) are ignored, the one at T+11 (done) starts the next frame.
        for (int k = 1; k <= 11; k++) begin
            tab[k].en     = (k == 4) || (k == 10) || (k == 11);
            tab[k].rd_en  = (k <= N);
            tab[k].addr_l = AW'(k - 1);
            tab[k].addr_r = (k <= N) ? rev_tab[k - 1] : '0;
            tab[k].vld    = (k >= 3) && (k <= N + 2);
            tab[k].im_l   = 16'(k - 3);
            tab[k].re_l   = 16'(k - 3 + 100);
            tab[k].im_r   = (k >= 3 && k <= N + 2) ? 16'(rev_tab[k - 3]) : 16'd0;
            tab[k].last   = (k == N + 2);
            tab[k].done   = (k == N + 3);
            tab[k].ready  = (k == N + 3);
        end

        // Reset with random inputs.
        for (int i = 0; i < 4; i++) begin
            tick();
            en      = 1'($urandom_range(0, 1));
            out_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_reset_outputs($sformatf("in_reset%0d", i));
        end
        en      = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
        end
        check_reset_outputs("after_release");

        // Table-driven linear / bit-reversed frame with busy and back-to-back en_in.
        tick();
        en = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            en = tab[k].en;
            @(negedge clk);
            check($sformatf("k=%0d rd_en", k), 32'({rd_en_l, rd_en_r}), tab[k].rd_en ? 32'd3 : 32'd0);
            if (tab[k].rd_en) begin
                check($sformatf("k=%0d addr_lin", k), 32'(rd_addr_l), 32'(tab[k].addr_l));
                check($sformatf("k=%0d addr_rev", k), 32'(rd_addr_r), 32'(tab[k].addr_r));
            end
            check($sformatf("k=%0d out_vld", k), 32'({out_vld_l, out_vld_r}), tab[k].vld ? 32'd3 : 32'd0);
            if (tab[k].vld) begin
                check($sformatf("k=%0d im_lin", k), 32'(out_im_l), 32'(tab[k].im_l));
                check($sformatf("k=%0d re_lin", k), 32'(out_re_l), 32'(tab[k].re_l));
                check($sformatf("k=%0d im_rev", k), 32'(out_im_r), 32'(tab[k].im_r));
            end
            check($sformatf("k=%0d last", k), 32'({out_last_l, out_last_r}), tab[k].last ? 32'd3 : 32'd0);
            check($sformatf("k=%0d done", k), 32'({done_l, done_r}), tab[k].done ? 32'd3 : 32'd0);
            check($sformatf("k=%0d ready", k), 32'({ready_l, ready_r}), tab[k].ready ? 32'd3 : 32'd0);
        end
        tick();
        en = 1'b0;
        @(negedge clk);
        check("b2b rd_en", 32'({rd_en_l, rd_en_r}), 32'd3);
        check("b2b rd_addr", 32'({rd_addr_l, rd_addr_r}), 32'd0);
        check("b2b ready", 32'(ready_l), 32'd0);

        // Second frame (already running) with a 5-cycle stall at the first out_vld.
        run_rest(1, "stall");

        // Idle after done: the busy-time en_in pulses must not have queued a frame.
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
        end
        check("idle ready", 32'({ready_l, ready_r}), 32'd3);
        check("idle rd_en", 32'({rd_en_l, rd_en_r}), 32'd0);

        // Random out_rdy pattern against the scoreboard.
        start_frame();
        run_rest(2, "random");

        // Reset after the third delivered sample, then a fresh full frame.
        start_frame();
        hs = 0;
        for (int c = 0; c < 50 && hs < 3; c++) begin
            @(negedge clk);
            if (out_vld_l && out_rdy) hs++;
            tick();
        end
        check("midreset handshakes", 32'(hs), 32'd3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        start_frame();
        check("restart rd_addr", 32'({rd_addr_l, rd_addr_r}), 32'd0);
        check("restart rd_en", 32'({rd_en_l, rd_en_r}), 32'd3);
        run_rest(0, "restart");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
